mips_cpu_bus_arbiter: RTL and testbench

//  Shares one Avalon-style memory port between the CPU instruction-fetch and data-access requesters.

---
 rtl/mips_cpu_bus_arbiter_if.sv | 47 ++++
 rtl/mips_cpu_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_arbiter_if.sv
// ============================================================================
// Module      : mips_cpu_bus_arbiter_if
// Description : Fetch, load/store and Avalon-style bus signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_cpu_bus_arbiter_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        busy;
    logic        bus_error;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;

    // Requesters plus bus slave: the environment around the arbiter
    modport master (
        output instr_req, instr_addr, data_req, data_we, data_addr, data_wdata, data_be,
        output bus_waitrequest, bus_readdata,
        input  instr_rdata, instr_valid, data_rdata, data_valid, busy, bus_error,
        input  bus_address, bus_read, bus_write, bus_writedata, bus_byteenable
    );

    // The arbiter itself
    modport slave (
        input  instr_req, instr_addr, data_req, data_we, data_addr, data_wdata, data_be,
        input  bus_waitrequest, bus_readdata,
        output instr_rdata, instr_valid, data_rdata, data_valid, busy, bus_error,
        output bus_address, bus_read, bus_write, bus_writedata, bus_byteenable
    );
endinterface

`default_nettype wire

// File: rtl/mips_cpu_bus_arbiter.sv
// ============================================================================
// Module      : mips_cpu_bus_arbiter
// Description : Round-robin arbiter sharing one Avalon-style port between
//               fetch and data requesters. Optional MIPS_BUS_TIMEOUT_EN aborts
//               accesses stalled for TIMEOUT_CYCLES waitrequest cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_cpu_bus_arbiter_if.slave       bus_if
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_IFETCH  = 2'd1;
    localparam logic [1:0] c_ST_DACCESS = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    localparam logic c_GRANT_INSTR = 1'b0;
    localparam logic c_GRANT_DATA  = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  r_state, w_state_next;
    logic        r_last_grant, w_last_grant_next;
    logic [31:0] r_instr_rdata, w_instr_rdata_next;
    logic        r_instr_valid, w_instr_valid_next;
    logic [31:0] r_data_rdata, w_data_rdata_next;
    logic        r_data_valid, w_data_valid_next;
    logic        r_bus_error, w_bus_error_next;
    logic [31:0] r_bus_address, w_bus_address_next;
    logic        r_bus_read, w_bus_read_next;
    logic        r_bus_write, w_bus_write_next;
    logic [31:0] r_bus_writedata, w_bus_writedata_next;
    logic [3:0]  r_bus_byteenable, w_bus_byteenable_next;

    logic w_grant_data;
    logic w_grant_instr;
    logic w_in_access;
    logic w_timeout;

    // Data wins a tie only when the fetch was granted last
    assign w_grant_data  = bus_if.data_req &
                           (~bus_if.instr_req | (r_last_grant == c_GRANT_INSTR));
    assign w_grant_instr = bus_if.instr_req & ~w_grant_data;
    assign w_in_access   = (r_state == c_ST_IFETCH) || (r_state == c_ST_DACCESS);

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int c_COUNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_COUNT_W-1:0] c_COUNT_LAST = c_COUNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_COUNT_W-1:0] r_wait_count;

    // Abort on the stalled cycle that brings the count to TIMEOUT_CYCLES
    assign w_timeout = w_in_access && bus_if.bus_waitrequest && (r_wait_count == c_COUNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset || (r_state == c_ST_IDLE)) begin
            r_wait_count <= '0;
        end else if (w_in_access && bus_if.bus_waitrequest) begin
            r_wait_count <= r_wait_count + c_COUNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= c_ST_IDLE;
            r_last_grant     <= c_GRANT_INSTR;
            r_instr_rdata    <= '0;
            r_instr_valid    <= 1'b0;
            r_data_rdata     <= '0;
            r_data_valid     <= 1'b0;
            r_bus_error      <= 1'b0;
            r_bus_address    <= '0;
            r_bus_read       <= 1'b0;
            r_bus_write      <= 1'b0;
            r_bus_writedata  <= '0;
            r_bus_byteenable <= '0;
        end else begin
            r_state          <= w_state_next;
            r_last_grant     <= w_last_grant_next;
            r_instr_rdata    <= w_instr_rdata_next;
            r_instr_valid    <= w_instr_valid_next;
            r_data_rdata     <= w_data_rdata_next;
            r_data_valid     <= w_data_valid_next;
            r_bus_error      <= w_bus_error_next;
            r_bus_address    <= w_bus_address_next;
            r_bus_read       <= w_bus_read_next;
            r_bus_write      <= w_bus_write_next;
            r_bus_writedata  <= w_bus_writedata_next;
            r_bus_byteenable <= w_bus_byteenable_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_data) begin
                    w_state_next = c_ST_DACCESS;
                end else if (w_grant_instr) begin
                    w_state_next = c_ST_IFETCH;
                end
            end
            c_ST_IFETCH, c_ST_DACCESS: begin
                if (!bus_if.bus_waitrequest || w_timeout) begin
                    w_state_next = c_ST_RESP;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; bus signals hold unless changed here
    always_comb begin
        w_last_grant_next     = r_last_grant;
        w_instr_rdata_next    = r_instr_rdata;
        w_instr_valid_next    = 1'b0;
        w_data_rdata_next     = r_data_rdata;
        w_data_valid_next     = 1'b0;
        w_bus_error_next      = 1'b0;
        w_bus_address_next    = r_bus_address;
        w_bus_read_next       = r_bus_read;
        w_bus_write_next      = r_bus_write;
        w_bus_writedata_next  = r_bus_writedata;
        w_bus_byteenable_next = r_bus_byteenable;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_data) begin
                    w_last_grant_next     = c_GRANT_DATA;
                    w_bus_address_next    = bus_if.data_addr;
                    w_bus_writedata_next  = bus_if.data_wdata;
                    w_bus_byteenable_next = bus_if.data_be;
                    w_bus_read_next       = ~bus_if.data_we;
                    w_bus_write_next      = bus_if.data_we;
                end else if (w_grant_instr) begin
                    w_last_grant_next     = c_GRANT_INSTR;
                    w_bus_address_next    = bus_if.instr_addr;
                    w_bus_byteenable_next = 4'b1111;
                    w_bus_read_next       = 1'b1;
                    w_bus_write_next      = 1'b0;
                end
            end
            c_ST_IFETCH, c_ST_DACCESS: begin
                if (!bus_if.bus_waitrequest || w_timeout) begin
                    w_bus_read_next  = 1'b0;
                    w_bus_write_next = 1'b0;
                    w_bus_error_next = w_timeout;
                    if (r_state == c_ST_IFETCH) begin
                        w_instr_valid_next = 1'b1;
                        w_instr_rdata_next = w_timeout ? 32'h0 : bus_if.bus_readdata;
                    end else begin
                        w_data_valid_next = 1'b1;
                        if (w_timeout) begin
                            w_data_rdata_next = 32'h0;
                        end else if (r_bus_read) begin
                            w_data_rdata_next = bus_if.bus_readdata;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus_if.busy           = (r_state != c_ST_IDLE);
    assign bus_if.instr_rdata    = r_instr_rdata;
    assign bus_if.instr_valid    = r_instr_valid;
    assign bus_if.data_rdata     = r_data_rdata;
    assign bus_if.data_valid     = r_data_valid;
    assign bus_if.bus_error      = r_bus_error;
    assign bus_if.bus_address    = r_bus_address;
    assign bus_if.bus_read       = r_bus_read;
    assign bus_if.bus_write      = r_bus_write;
    assign bus_if.bus_writedata  = r_bus_writedata;
    assign bus_if.bus_byteenable = r_bus_byteenable;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
// ============================================================================
// Module      : tb_mips_cpu_bus_arbiter
// Description : Directed scoreboard bench for mips_cpu_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_bus_arbiter;

    localparam logic [31:0] c_KEY = 32'h9BC2_0005;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;

    mips_cpu_bus_arbiter_if bif ();

    mips_cpu_bus_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bif)
    );

    // Slave read data is a fixed function of the address, so expectations are computable
    assign bif.bus_readdata = bif.bus_address ^ c_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic is_data, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        e.err     = err;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (bif.instr_valid || bif.data_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: actual instr_valid=%b data_valid=%b required none",
                         bif.instr_valid, bif.data_valid);
            end else begin
                mon_e = sb.pop_front();
                check("resp_kind", {31'b0, bif.data_valid}, {31'b0, mon_e.is_data});
                check("resp_single", {31'b0, bif.instr_valid & bif.data_valid}, 32'h0);
                check("resp_rdata", mon_e.is_data ? bif.data_rdata : bif.instr_rdata, mon_e.rdata);
                check("resp_error", {31'b0, bif.bus_error}, {31'b0, mon_e.err});
            end
        end else if (bif.bus_error) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_error: actual bus_error=1 required 0");
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bif.instr_req       = 1'b0;
        bif.instr_addr      = '0;
        bif.data_req        = 1'b0;
        bif.data_we         = 1'b0;
        bif.data_addr       = '0;
        bif.data_wdata      = '0;
        bif.data_be         = 4'hF;
        bif.bus_waitrequest = 1'b0;

        do_reset();
        check("rst_busy", {31'b0, bif.busy}, 32'h0);
        check("rst_read", {31'b0, bif.bus_read}, 32'h0);
        check("rst_write", {31'b0, bif.bus_write}, 32'h0);
        check("rst_addr", bif.bus_address, 32'h0);
        check("rst_be", {28'b0, bif.bus_byteenable}, 32'h0);
        check("rst_valids", {30'b0, bif.instr_valid, bif.data_valid}, 32'h0);

        // Single fetch, no wait states
        sb.push_back(mk(1'b0, 32'h2402_0005, 1'b0));
        bif.instr_req  = 1'b1;
        bif.instr_addr = 32'hBFC0_0000;
        tick();
        check("fetch_read", {31'b0, bif.bus_read}, 32'h1);
        check("fetch_addr", bif.bus_address, 32'hBFC0_0000);
        check("fetch_be", {28'b0, bif.bus_byteenable}, 32'hF);
        check("fetch_busy", {31'b0, bif.busy}, 32'h1);
        tick();
        bif.instr_req = 1'b0;
        check("fetch_read_drop", {31'b0, bif.bus_read}, 32'h0);
        tick();
        check("fetch_idle", {31'b0, bif.busy}, 32'h0);

        // Write held by three wait states; data_rdata keeps its old value
        sb.push_back(mk(1'b1, 32'h0, 1'b0));
        bif.data_req        = 1'b1;
        bif.data_we         = 1'b1;
        bif.data_addr       = 32'h0000_1000;
        bif.data_wdata      = 32'hCAFE_F00D;
        bif.data_be         = 4'b0011;
        bif.bus_waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) bif.bus_waitrequest = 1'b0;
            check("wr_write", {31'b0, bif.bus_write}, 32'h1);
            check("wr_addr", bif.bus_address, 32'h0000_1000);
            check("wr_data", bif.bus_writedata, 32'hCAFE_F00D);
            check("wr_be", {28'b0, bif.bus_byteenable}, 32'h3);
        end
        tick();
        bif.data_req = 1'b0;
        check("wr_write_drop", {31'b0, bif.bus_write}, 32'h0);
        tick();

        // Simultaneous requests from reset: data first, then the fetch
        do_reset();
        bif.data_be = 4'hF;
        bif.data_we = 1'b0;
        sb.push_back(mk(1'b1, 32'h0000_2000 ^ c_KEY, 1'b0));
        sb.push_back(mk(1'b0, 32'h0000_0100 ^ c_KEY, 1'b0));
        bif.instr_req  = 1'b1;
        bif.instr_addr = 32'h0000_0100;
        bif.data_req   = 1'b1;
        bif.data_addr  = 32'h0000_2000;
        tick();
        check("arb_first_data", bif.bus_address, 32'h0000_2000);
        tick();
        bif.data_req = 1'b0;
        tick();
        tick();
        check("arb_then_instr", bif.bus_address, 32'h0000_0100);
        tick();
        bif.instr_req = 1'b0;
        tick();
        // Data-only transfer, then a new pair: the fetch must win
        sb.push_back(mk(1'b1, 32'h0000_3000 ^ c_KEY, 1'b0));
        bif.data_req  = 1'b1;
        bif.data_addr = 32'h0000_3000;
        tick();
        tick();
        bif.data_req = 1'b0;
        tick();
        sb.push_back(mk(1'b0, 32'h0000_0200 ^ c_KEY, 1'b0));
        sb.push_back(mk(1'b1, 32'h0000_4000 ^ c_KEY, 1'b0));
        bif.instr_req  = 1'b1;
        bif.instr_addr = 32'h0000_0200;
        bif.data_req   = 1'b1;
        bif.data_addr  = 32'h0000_4000;
        tick();
        check("arb_rr_instr", bif.bus_address, 32'h0000_0200);
        tick();
        bif.instr_req = 1'b0;
        tick();
        tick();
        check("arb_rr_data", bif.bus_address, 32'h0000_4000);
        tick();
        bif.data_req = 1'b0;
        tick();

        // Reset while a fetch is stalled
        bif.instr_req       = 1'b1;
        bif.instr_addr      = 32'h0000_0300;
        bif.bus_waitrequest = 1'b1;
        tick();
        check("rstmid_read_on", {31'b0, bif.bus_read}, 32'h1);
        tick();
        reset         = 1'b0;
        bif.instr_req = 1'b0;
        tick();
        check("rstmid_read_off", {31'b0, bif.bus_read}, 32'h0);
        check("rstmid_busy", {31'b0, bif.busy}, 32'h0);
        reset               = 1'b1;
        bif.bus_waitrequest = 1'b0;
        sb.push_back(mk(1'b0, 32'h0000_0400 ^ c_KEY, 1'b0));
        bif.instr_req  = 1'b1;
        bif.instr_addr = 32'h0000_0400;
        tick();
        check("rstmid_refetch", {31'b0, bif.bus_read}, 32'h1);
        tick();
        bif.instr_req = 1'b0;
        tick();

        // Data read with waitrequest stuck high
        bif.data_req        = 1'b1;
        bif.data_we         = 1'b0;
        bif.data_addr       = 32'h0000_5000;
        bif.bus_waitrequest = 1'b1;
`ifdef MIPS_BUS_TIMEOUT_EN
        sb.push_back(mk(1'b1, 32'h0, 1'b1));
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("to_read_held", {31'b0, bif.bus_read}, 32'h1);
        end
        tick();
        check("to_read_drop", {31'b0, bif.bus_read}, 32'h0);
        bif.data_req        = 1'b0;
        bif.bus_waitrequest = 1'b0;
        tick();
`else
        for (int k = 1; k <= 100; k++) begin
            tick();
            check("stuck_read", {30'b0, bif.bus_read, bif.bus_error}, 32'h2);
        end
        sb.push_back(mk(1'b1, 32'h0000_5000 ^ c_KEY, 1'b0));
        bif.bus_waitrequest = 1'b0;
        tick();
        bif.data_req = 1'b0;
        tick();
`endif

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
